// File: rtl/arb_req_queue_if.sv
// Handshake bundle between the four-channel request queue, its producers,
// the round-robin arbiter and the downstream consumer.
interface arb_req_queue_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          push;
  logic [4*DATA_W-1:0] push_data;
  logic [3:0]          full;
  logic [3:0]          req;
  logic [3:0]          grant;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic [3:0]          overflow;
  logic                grant_err;

  modport master (
    output push, push_data, grant,
    input  full, req, out_valid, out_data, out_id, overflow, grant_err
  );

  modport slave (
    input  push, push_data, grant,
    output full, req, out_valid, out_data, out_id, overflow, grant_err
  );
endinterface

// File: rtl/arb_req_queue.sv
// Four per-channel FIFOs feeding a round-robin arbiter; the granted head
// entry is popped onto one registered output tagged with its channel id.
module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            reset,
  arb_req_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem   [4][DEPTH];
  logic [PW-1:0]     wptr  [4];
  logic [PW-1:0]     rptr  [4];
  logic [CW-1:0]     count [4];

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        out_id_q;
  logic [3:0]        overflow_q;
  logic              grant_err_q;

  logic [3:0] do_push;
  logic [3:0] do_pop;
  logic [3:0] drop;
  logic [1:0] gidx;
  logic       grant_onehot;
  logic       grant_multi;
  logic       grant_stale_ok;
  logic       grant_err_d;

  // NOTE: every variable written here gets a default first, so no latch can form.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.grant[i]) gidx = 2'(i);
    end
    grant_onehot = (bus.grant != 4'b0) && ((bus.grant & (bus.grant - 4'd1)) == 4'b0);
    grant_multi  = (bus.grant != 4'b0) && !grant_onehot;
    for (int i = 0; i < 4; i++) begin
      do_push[i] = bus.push[i] && (count[i] != FULL_CNT);
      drop[i]    = bus.push[i] && (count[i] == FULL_CNT);
      do_pop[i]  = grant_onehot && bus.grant[i] && (count[i] != '0);
    end
    // A grant that lags the drain of its channel by one cycle is expected.
    grant_stale_ok = out_valid_q && (out_id_q == gidx);
    grant_err_d    = grant_multi ||
                     (grant_onehot && (count[gidx] == '0) && !grant_stale_ok);
  end

  // NOTE: payload storage is not reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && do_push[i]) mem[i][wptr[i]] <= bus.push_data[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      overflow_q  <= '0;
      grant_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (do_push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (do_pop[i])  rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(do_push[i]) - CW'(do_pop[i]);
      end
      out_valid_q <= |do_pop;
      if (|do_pop) begin
        out_data_q <= mem[gidx][rptr[gidx]];
        out_id_q   <= gidx;
      end
      overflow_q  <= overflow_q | drop;
      grant_err_q <= grant_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.full[i] = (count[i] == FULL_CNT);
      bus.req[i]  = (count[i] != '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.overflow  = overflow_q;
  assign bus.grant_err = grant_err_q;
endmodule
